mp_addsub_seq: RTL and testbench

MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

---
 rtl/mp_addsub_seq_if.sv | 41 ++++
 rtl/mp_addsub_seq.sv | 123 ++++++++++++
 tb/tb_mp_addsub_seq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_addsub_seq_if.sv
// Byte-serial add/subtract bus: start/config, operand stream in, result stream out, status.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on results.
//
// Signals:
//   start, op, cin, len        operation request and configuration (latched by the block at start)
//   in_valid/in_ready, a_in, b_in   operand byte pair stream, least-significant byte first
//   out_valid/out_ready, s_out      result byte stream, least-significant byte first
//   busy, done                 operation status
//   c_flag, v_flag, n_flag, z_flag  final carry, overflow, negative, zero flags
interface mp_addsub_seq_if;
    logic       start;
    logic       op;
    logic       cin;
    logic [2:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s_out;
    logic       busy;
    logic       done;
    logic       c_flag;
    logic       v_flag;
    logic       n_flag;
    logic       z_flag;

    // master drives requests and operands, consumes results
    modport master (
        output start, op, cin, len, in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, s_out, busy, done, c_flag, v_flag, n_flag, z_flag
    );

    // slave is the arithmetic block itself
    modport slave (
        input  start, op, cin, len, in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, s_out, busy, done, c_flag, v_flag, n_flag, z_flag
    );
endinterface

// File: rtl/mp_addsub_seq.sv
// Multi-precision (1..8 byte) add/subtract, one byte per accepted operand pair, LSB first.
// Latency: 1 cycle from operand accept to out_valid; 1 byte/cycle sustained with out_ready=1.
// Backpressure: a stalled result (out_valid & ~out_ready) holds s_out and drops in_ready.
//
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mp_addsub_seq_if.slave (config, operand stream, result stream, status, flags)
module mp_addsub_seq (
    input  logic             clk,
    input  logic             reset_n,
    mp_addsub_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic       op_l;
    logic [2:0] len_l;
    logic [2:0] cnt;
    logic       carry;
    logic       zacc;
    logic       out_valid_r;
    logic [7:0] s_out_r;
    logic       done_r;
    logic       c_r;
    logic       v_r;
    logic       n_r;
    logic       z_r;

    logic [7:0] b_eff;
    logic [8:0] t;
    logic       accept;
    logic       out_hs;
    logic       last;
    logic       t_zero;

    // Subtract is a + ~b + carry; carry holds cin for byte 0 (loaded at start).
    assign b_eff  = op_l ? ~bus.b_in : bus.b_in;
    assign t      = {1'b0, bus.a_in} + {1'b0, b_eff} + {8'd0, carry};
    assign t_zero = (t[7:0] == 8'd0);

    // Operands may only enter when the output register is free or draining this cycle.
    assign bus.in_ready = (state == RUN) && (!out_valid_r || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_hs       = out_valid_r && bus.out_ready;
    assign last         = (cnt == len_l);

    assign bus.out_valid = out_valid_r;
    assign bus.s_out     = s_out_r;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.c_flag    = c_r;
    assign bus.v_flag    = v_r;
    assign bus.n_flag    = n_r;
    assign bus.z_flag    = z_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op_l        <= 1'b0;
            len_l       <= 3'd0;
            cnt         <= 3'd0;
            carry       <= 1'b0;
            zacc        <= 1'b1;
            out_valid_r <= 1'b0;
            s_out_r     <= 8'd0;
            done_r      <= 1'b0;
            c_r         <= 1'b0;
            v_r         <= 1'b0;
            n_r         <= 1'b0;
            z_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_l  <= bus.op;
                        carry <= bus.cin;
                        len_l <= bus.len;
                        cnt   <= 3'd0;
                        zacc  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        // A new byte replaces the old one even if it handshakes this cycle.
                        s_out_r     <= t[7:0];
                        out_valid_r <= 1'b1;
                        carry       <= t[8];
                        zacc        <= zacc & t_zero;
                        cnt         <= cnt + 3'd1;
                        if (last) begin
                            c_r   <= t[8];
                            n_r   <= t[7];
                            z_r   <= zacc & t_zero;
                            // Signed overflow of the top byte, with b already inverted for subtract.
                            v_r   <= (op_l ^ t[7] ^ bus.b_in[7]) & (~op_l ^ bus.a_in[7] ^ bus.b_in[7]);
                            state <= DRAIN;
                        end
                    end else if (out_hs) begin
                        out_valid_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    // done lands in the first IDLE cycle, where a new start is already legal.
                    if (out_hs) begin
                        out_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Scoreboard bench for mp_addsub_seq: multi-byte integer reference model, randomized operations.
// Latency: n/a.
// Backpressure: random and directed out_ready stalls, random in_valid gaps.
module tb_mp_addsub_seq;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    mp_addsub_seq_if bus ();

    mp_addsub_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    bit         mon_en   = 1'b0;
    bit         bp_rand  = 1'b0;
    bit         gap_rand = 1'b0;
    logic       or_man   = 1'b1;
    logic [7:0] exp_q[$];
    logic [3:0] flag_q[$];
    logic [3:0] last_flags = 4'd0;
    int         first_acc = 0;
    int         last_acc  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.c_flag, bus.v_flag, bus.n_flag, bus.z_flag};
    endfunction

    // Whole-number reference: treat the operands as (len+1)-byte integers.
    task automatic model(input logic op, input logic cin, input logic [2:0] len,
                         input logic [63:0] a, input logic [63:0] b);
        int          nb;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bb;
        logic [63:0] r;
        logic [64:0] full;
        logic        c, v, n, z, sa, sb;
        nb   = int'(len) + 1;
        mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
        am   = a & mask;
        bb   = (op ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, bb} + {64'd0, cin};
        r    = full[63:0] & mask;
        c    = full[8 * nb];
        n    = r[8 * nb - 1];
        z    = (r == 64'd0);
        sa   = am[8 * nb - 1];
        sb   = bb[8 * nb - 1];
        v    = (sa == sb) && (n != sa);
        for (int i = 0; i < nb; i++) exp_q.push_back(r[8 * i +: 8]);
        flag_q.push_back({c, v, n, z});
        last_flags = {c, v, n, z};
    endtask

    task automatic send_op(input logic op, input logic cin, input logic [2:0] len,
                           input logic [63:0] a, input logic [63:0] b, input bit inj);
        int  prev_done;
        int  n;
        bit  ok;
        model(op, cin, len, a, b);
        prev_done = done_cnt;
        bus.start = 1'b1;
        bus.op    = op;
        bus.cin   = cin;
        bus.len   = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gap_rand && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (inj && i == 1) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.cin   = ~cin;
                bus.len   = 3'd0;
            end
            bus.in_valid = 1'b1;
            bus.a_in     = a[8 * i +: 8];
            bus.b_in     = b[8 * i +: 8];
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 200) begin
                @(negedge clk);
                if (bus.in_ready) ok = 1'b1;
                n++;
            end
            if (!ok) fail_now("accept_wait");
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 400) begin
            @(negedge clk);
            if (!bus.busy) ok = 1'b1;
            n++;
        end
        if (!ok) fail_now("idle_wait");
        repeat (2) @(negedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - prev_done), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("flags_hold", 64'(flags_now()), 64'(last_flags));
        @(posedge clk); #1;
    endtask

    // Single writer of out_ready: random when enabled, else the directed value.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : or_man;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare each output handshake and each done pulse against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: got %0h expected none", bus.s_out);
                end else begin
                    chk("s_out", 64'(bus.s_out), 64'(exp_q.pop_front()));
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (flag_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    chk("flags_cvnz", 64'(flags_now()), 64'(flag_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb;
        logic [2:0]  rl;
        logic        held;
        logic [7:0]  held_s;
        int          n;

        bus.start    = 1'b0;
        bus.op       = 1'b0;
        bus.cin      = 1'b0;
        bus.len      = 3'd0;
        bus.in_valid = 1'b0;
        bus.a_in     = 8'd0;
        bus.b_in     = 8'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.done, flags_now(), bus.s_out}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        // Single-byte add overflowing into the sign bit
        send_op(1'b0, 1'b0, 3'd0, 64'h50, 64'h50, 1'b0);
        chk("add1_flags", 64'(flags_now()), 64'b0110);

        // Reset in the middle of a 4-byte operation
        mon_en    = 1'b0;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.cin   = 1'b0;
        bus.len   = 3'd3;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_in     = 8'h12;
        bus.b_in     = 8'h34;
        @(posedge clk); #1;
        bus.a_in     = 8'h56;
        bus.b_in     = 8'h78;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async_outs", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.done, flags_now(), bus.s_out}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        send_op(1'b0, 1'b1, 3'd0, 64'h7F, 64'h01, 1'b0);

        // Two-byte subtract 0x0100 - 0x0001
        send_op(1'b1, 1'b1, 3'd1, 64'h0100, 64'h0001, 1'b0);
        chk("sub2_flags", 64'(flags_now()), 64'b1000);

        // Eight-byte add rolling over to zero, fully streamed
        send_op(1'b0, 1'b0, 3'd7, {64{1'b1}}, 64'h1, 1'b0);
        chk("add8_flags", 64'(flags_now()), 64'b1001);
        chk("add8_accept_span", 64'(last_acc - first_acc), 64'd7);

        // Three-cycle stall right after the first output byte
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        fork
            send_op(1'b0, 1'b0, 3'd3, ra, rb, 1'b0);
            begin
                held = 1'b0;
                n    = 0;
                while (!held && n < 100) begin
                    @(posedge clk); #1;
                    if (bus.out_valid) held = 1'b1;
                    n++;
                end
                if (!held) fail_now("bp_first_out");
                or_man = 1'b0;
                held_s = bus.s_out;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    chk("bp_s_out_held", 64'(bus.s_out), 64'(held_s));
                end
                @(posedge clk); #1;
                or_man = 1'b1;
            end
        join

        // start pulsed mid-operation with different op/len/cin must be ignored
        send_op(1'b0, 1'b0, 3'd2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

        // Randomized operations with random stalls and input gaps
        bp_rand  = 1'b1;
        gap_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rl = 3'($urandom_range(0, 7));
            send_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rl, ra, rb,
                    (rl != 3'd0) && ($urandom_range(0, 3) == 0));
        end
        bp_rand  = 1'b0;
        gap_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
